// File: rtl/ctr_pkg.sv
// Shared definitions for the counter-sharing controller and the counter it drives.
// No logic; only the counter width and the controller state encoding.
// Not applicable: this package has no flow control.
package ctr_pkg;

    // Width of counter_9bit; the controller targets must match it.
    localparam int CTR_WIDTH = 9;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a registered priority pointer.
// Latency: win is combinational from req; the pointer updates on the edge where advance is high.
// Backpressure: none; the caller pulses advance only when it accepts the winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] win
);

    // prio_q=0 favours req[0] on a tie, prio_q=1 favours req[1]
    logic prio_q;
    logic prio_d;

    // Single requests win outright; a tie is broken by the priority pointer
    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = prio_q ? 2'b10 : 2'b01;
        end
    end

    // After serving req[0], favour req[1] next time, and vice versa
    always_comb begin
        prio_d = prio_q;
        if (advance) begin
            prio_d = win[0];
        end
    end

    // Pointer register; reset favours req[0]
    always_ff @(posedge clk) begin
        if (clr) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ctr_share_ctrl.sv
// Arbitrates two requesters onto one external counter_9bit and runs it to the winner's target.
// Latency: grant at N+1, counter cleared at N+1, done pulse at N+3+T (plus one per hold cycle in RUN).
// Backpressure: requesters hold req until done; dropping req aborts; hold pauses counting in RUN.
module ctr_share_ctrl
    import ctr_pkg::*;
#(
    parameter int WIDTH = CTR_WIDTH,
    parameter int NREQ  = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [NREQ-1:0]  req,
    input  logic [WIDTH-1:0] target0,
    input  logic [WIDTH-1:0] target1,
    input  logic             hold,
    input  logic [WIDTH-1:0] ctr_q,
    output logic             ctr_en,
    output logic             ctr_clr,
    output logic [NREQ-1:0]  grant,
    output logic [NREQ-1:0]  done,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [NREQ-1:0]  win;
    logic             arb_adv;
    logic             req_gnt;
    logic             match;
    logic             run_en;

    // Granted requester still asking, and counter sitting on the latched target
    assign req_gnt = |(req & grant_q);
    assign match   = (ctr_q == tgt_q);

    rr_arb2 u_arb (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .advance (arb_adv),
        .win     (win)
    );

    // Next-state, grant and target latch, plus the counter enable in RUN
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        tgt_d   = tgt_q;
        arb_adv = 1'b0;
        run_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    arb_adv = 1'b1;
                    grant_d = win;
                    tgt_d   = win[1] ? target1 : target0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (!req_gnt) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Enable is gated by req so an abort leaves the counter on its current value
                run_en = req_gnt && !match && !hold;
                if (!req_gnt) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else if (match) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant and target registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            tgt_q   <= tgt_d;
        end
    end

    // Counter is also cleared while reset is held, so a reset mid-run leaves it at zero
    assign ctr_clr = clr || (state_q == ST_CLEAR);
    assign ctr_en  = run_en && !clr;
    assign grant   = grant_q;
    assign done    = (state_q == ST_DONE) ? grant_q : '0;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ctr_share_ctrl.sv
module tb_ctr_share_ctrl;

    logic       clk;
    logic       clr;
    logic [1:0] req;
    logic [8:0] target0;
    logic [8:0] target1;
    logic       hold;
    logic [8:0] cnt;
    logic       ctr_en;
    logic       ctr_clr;
    logic [1:0] grant;
    logic [1:0] done;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ctr_share_ctrl #(.WIDTH(9), .NREQ(2)) dut (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .target0 (target0),
        .target1 (target1),
        .hold    (hold),
        .ctr_q   (cnt),
        .ctr_en  (ctr_en),
        .ctr_clr (ctr_clr),
        .grant   (grant),
        .done    (done),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared counter_9bit: clear wins, wraps naturally at 511
    always @(posedge clk) begin
        if (ctr_clr) cnt <= 9'd0;
        else if (ctr_en) cnt <= cnt + 9'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Scoreboard of expected done pulses: which bit, cycle of the pulse, counter value
    typedef struct {
        logic [1:0] d;
        int         c;
        logic [8:0] v;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (done !== 2'b00) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done got=%b want=none cyc=%0d", done, cyc);
            end else begin
                e = sb.pop_front();
                chk("done_bits", done, e.d);
                chk("done_cycle", cyc, e.c);
                chk("done_cnt", cnt, e.v);
            end
        end
    end

    typedef struct {
        logic [1:0] rq;
        logic [8:0] t0;
        logic [8:0] t1;
        logic [1:0] gnt;
        int         tv;
    } vec_t;
    vec_t vecs[8];

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait_timeout", busy, 0);
    endtask

    initial begin
        bit seen;
        int c0;
        int nd;
        int hc;
        bit held;

        vecs[0] = '{rq: 2'b01, t0: 9'd5,   t1: 9'd0,   gnt: 2'b01, tv: 5};
        vecs[1] = '{rq: 2'b10, t0: 9'd0,   t1: 9'd7,   gnt: 2'b10, tv: 7};
        vecs[2] = '{rq: 2'b01, t0: 9'd0,   t1: 9'd9,   gnt: 2'b01, tv: 0};
        vecs[3] = '{rq: 2'b10, t0: 9'd3,   t1: 9'd0,   gnt: 2'b10, tv: 0};
        vecs[4] = '{rq: 2'b01, t0: 9'd1,   t1: 9'd0,   gnt: 2'b01, tv: 1};
        vecs[5] = '{rq: 2'b10, t0: 9'd0,   t1: 9'd2,   gnt: 2'b10, tv: 2};
        vecs[6] = '{rq: 2'b01, t0: 9'd511, t1: 9'd0,   gnt: 2'b01, tv: 511};
        vecs[7] = '{rq: 2'b10, t0: 9'd0,   t1: 9'd511, gnt: 2'b10, tv: 511};

        clr = 1'b1; req = 2'b00; hold = 1'b0; target0 = '0; target1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ctr_en", ctr_en, 0);
        chk("rst_ctr_clr", ctr_clr, 1);
        chk("rst_cnt", cnt, 0);
        clr = 1'b0;
        @(negedge clk);

        // Table of single-requester runs
        for (int i = 0; i < 8; i++) begin
            wait_idle();
            req = vecs[i].rq; target0 = vecs[i].t0; target1 = vecs[i].t1;
            sb.push_back('{d: vecs[i].gnt, c: cyc + 3 + vecs[i].tv, v: vecs[i].tv[8:0]});
            seen = 1'b0;
            for (int k = 1; k <= vecs[i].tv + 10; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    chk("vec_grant", grant, vecs[i].gnt);
                    chk("vec_ctr_clr", ctr_clr, 1);
                    target0 = 9'd77; target1 = 9'd33;
                end
                if (k == 2) chk("vec_ctr_en_first", ctr_en, (vecs[i].tv != 0));
                if (done != 2'b00) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("vec_done_seen", seen, 1);
            req = 2'b00;
            @(negedge clk);
            chk("vec_grant_drop", grant, 0);
            chk("vec_cnt_hold", cnt, vecs[i].tv);
        end

        // Both requesting from reset: 0, then 1, then 0 again
        wait_idle();
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        req = 2'b11; target0 = 9'd3; target1 = 9'd4;
        c0 = cyc;
        sb.push_back('{d: 2'b01, c: c0 + 6,  v: 9'd3});
        sb.push_back('{d: 2'b10, c: c0 + 14, v: 9'd4});
        sb.push_back('{d: 2'b01, c: c0 + 21, v: 9'd3});
        nd = 0;
        for (int k = 0; k < 60 && nd < 3; k++) begin
            @(negedge clk);
            if (done != 2'b00) nd++;
        end
        chk("rr_three_dones", nd, 3);
        req = 2'b00;

        // Hold for four cycles at count 6
        wait_idle();
        req = 2'b10; target1 = 9'd10;
        sb.push_back('{d: 2'b10, c: cyc + 17, v: 9'd10});
        held = 1'b0; hc = 0; seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                seen = 1'b1;
                break;
            end
            if (held && hold) begin
                hc++;
                if (hc == 4) begin
                    hold = 1'b0;
                    chk("hold_frozen_cnt", cnt, 6);
                end
            end else if (!held && cnt == 9'd6 && busy) begin
                hold = 1'b1;
                held = 1'b1;
            end
        end
        chk("hold_done_seen", seen, 1);
        req = 2'b00; hold = 1'b0;

        // Abort by dropping req at count 50
        wait_idle();
        req = 2'b01; target0 = 9'd200;
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (cnt == 9'd50 && busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk("abort_reach50", seen, 1);
        req = 2'b00;
        @(negedge clk);
        chk("abort_grant", grant, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cnt", cnt, 50);
        repeat (3) @(negedge clk);
        chk("abort_cnt_later", cnt, 50);
        chk("abort_ctr_en", ctr_en, 0);

        // Reset mid-run at count 100
        req = 2'b01; target0 = 9'd300;
        seen = 1'b0;
        for (int k = 0; k < 130; k++) begin
            @(negedge clk);
            if (cnt == 9'd100 && busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk("clr_reach100", seen, 1);
        clr = 1'b1;
        @(negedge clk);
        chk("clr_ctr_en", ctr_en, 0);
        chk("clr_grant", grant, 0);
        chk("clr_busy", busy, 0);
        chk("clr_cnt", cnt, 0);
        req = 2'b00;
        clr = 1'b0;
        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctr_share_ctrl.md
Name: ctr_share_ctrl

Overview:
- Controller and arbiter that shares one counter_9bit instance between two requesters.
- Each requester asks for a count run to a 9-bit target. The block arbitrates round-robin, then sequences the counter's enable and clear.
- It stops the counter exactly at the target and returns a one-cycle done pulse to the winning requester.
- It sits beside counter_9bit: drives its enable/clear inputs and observes its 9-bit output.

Parameters:
- WIDTH, 9, counter and target width; must match the shared counter.
- NREQ, 2, number of requesters; fixed at 2 for this revision.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset; synchronous, active-high.
- req  in  2  per-requester request; held high until that requester's done, or dropped to abort.
- target0  in  9  requester 0 target count; sampled only at grant.
- target1  in  9  requester 1 target count; sampled only at grant.
- hold  in  1  global pause; freezes counting while in RUN.
- ctr_q  in  9  output of the shared counter_9bit.
- ctr_en  out  1  enable to the shared counter.
- ctr_clr  out  1  clear to the shared counter.
- grant  out  2  one-hot registered grant; 00 when idle.
- done  out  2  one-cycle pulse to the granted requester when its target is reached.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (clr=1 at an edge):
  - state=IDLE, grant=00, done=00, busy=0, rr pointer favours req[0].
  - ctr_clr = clr OR (state==CLEAR), so the shared counter is also cleared while clr is high.
  - ctr_en=0 during reset.
  - Reset mid-run abandons the run with no done.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - If any req is high, pick the winner. When both are high, the winner is the requester not served last; after reset req[0] wins.
  - Latch the winner's target into tgt_r, set grant one-hot, update the rr pointer, go to CLEAR.
- CLEAR:
  - ctr_clr=1, ctr_en=0 for exactly one cycle, then go to RUN.
  - If the granted req is low, abort: go to IDLE, grant=00, no done.
- RUN:
  - ctr_en = (ctr_q != tgt_r) AND NOT hold. This is combinational, so the counter stops on the target value and never overshoots.
  - When ctr_q == tgt_r, go to DONE.
  - If the granted req drops, go to IDLE next cycle with ctr_en=0 and no done; the counter holds its value.
- DONE:
  - done[granted]=1 for this single cycle; grant stays asserted.
  - Next cycle go to IDLE with grant=00.
- Latency, with req rising while IDLE in cycle N:
  - grant is high from N+1; CLEAR is at N+1.
  - RUN starts at N+2 with ctr_q=0.
  - ctr_q reaches target T at N+2+T.
  - done is high at N+3+T.
  - grant drops at N+4+T.
  - Each hold cycle adds one cycle.
- Boundaries:
  - T=0: RUN sees the match immediately, ctr_en is never asserted, and done comes at N+3.
  - T=511: the full range is reached with no wrap, because the stop happens before the counter rolls over.
  - Requests arriving outside IDLE wait; there is no preemption.
  - target inputs are ignored after grant.
  - A req still high after done is re-arbitrated normally in IDLE.
  - hold in IDLE/CLEAR/DONE has no effect.
  - Simultaneous hold and match: the transition to DONE still occurs.

Decomposition:
- Shared package (ctr_pkg) holds:
  - the state encoding localparams (IDLE/CLEAR/RUN/DONE);
  - CTR_WIDTH=9, shared with counter_9bit and its benches.
- One natural sub-module, rr_arb2: a two-input round-robin arbiter with a last-grant register. Inputs: clk, clr, req, advance. Output: one-hot win.
- counter_9bit is instantiated outside this block, in the wrapper or bench, not inside it.

Test Plan:
- Reset release, req=01, target0=5 → grant=01 from the cycle after the request; ctr_clr high one cycle; ctr_q steps 0..5 and holds at 5; done=01 pulse 8 cycles after the request; grant=00 next cycle.
- req=11 from reset, target0=3, target1=4, both held through their done → req0 served first (done=01), then req1 granted; ctr_q cleared and counts to 4; done=10. Third round goes back to req0.
- target0=0 → no ctr_en pulse; done=01 three cycles after the request; ctr_q stays 0.
- target1=10; hold high for 4 cycles at ctr_q=6 → ctr_q freezes at 6; done delayed exactly 4 cycles versus the unheld run.
- target0=200; req[0] dropped at ctr_q=50 → next cycle IDLE, grant=00, no done, ctr_en=0, ctr_q holds 50.
- clr asserted at ctr_q=100 → next edge: state IDLE, grant=00, ctr_q=0 via ctr_clr; no done. Separately, target=511 reaches 511 and does not wrap.
